// File: rtl/lfsr_gen_if.sv
// Control and status bundle for the lfsr_gen pattern generator.
// The master drives the step/seed/measure controls; the slave (the generator) returns state and status.
interface lfsr_gen_if #(
    parameter int WIDTH = 20
);
    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             meas_start;
    logic [WIDTH-1:0] state;
    logic             bit_out;
    logic             meas_busy;
    logic             meas_done;
    logic             meas_abort;
    logic [WIDTH-1:0] period;
    logic             lockup;

    modport master (
        output enable, seed_load, seed, meas_start,
        input  state, bit_out, meas_busy, meas_done, meas_abort, period, lockup
    );

    modport slave (
        input  enable, seed_load, seed, meas_start,
        output state, bit_out, meas_busy, meas_done, meas_abort, period, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with runtime seed load and an in-hardware period-measurement FSM.
// Optional all-zero lockup recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_gen #(
    parameter int               WIDTH      = 20,
    parameter logic [WIDTH-1:0] TAPS       = 20'h00008,
    parameter logic [WIDTH-1:0] RESET_SEED = 20'h00001
) (
    input  logic     clk,
    input  logic     reset,
    lfsr_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ZERO_C  = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   ONE_C   = {{WIDTH{1'b0}}, 1'b1};

    // Bit 0 of the tap mask never takes part: stage 0 always receives the raw feedback bit.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = s[WIDTH-1];
        galois_step = {s[WIDTH-2:0], fb} ^ ({TAPS[WIDTH-1:1], 1'b0} & {WIDTH{fb}});
    endfunction

    logic [WIDTH-1:0] state_r, state_nxt_s, step_s;
    logic [WIDTH-1:0] ref_state_r, ref_state_nxt_s;
    logic [WIDTH-1:0] period_r, period_nxt_s;
    logic [WIDTH:0]   cnt_r, cnt_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             abort_r, abort_nxt_s;
    logic             lockup_r;
    logic             recover_s;
    fsm_t             fsm_r, fsm_nxt_s;

    // Lockup detection and state-register next value (seed_load beats recovery beats stepping).
    always_comb begin
        step_s = galois_step(state_r);
`ifdef LFSR_LOCKUP_RECOVER_EN
        recover_s = (state_r == ZERO_W) && bus.enable && !bus.seed_load;
`else
        recover_s = 1'b0;
`endif
        state_nxt_s = state_r;
        if (bus.seed_load) begin
            state_nxt_s = bus.seed;
        end else if (recover_s) begin
            state_nxt_s = RESET_SEED;
        end else if (bus.enable) begin
            state_nxt_s = step_s;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Period-measurement FSM: next state and registered-output next values.
    always_comb begin
        fsm_nxt_s       = fsm_r;
        cnt_nxt_s       = cnt_r;
        ref_state_nxt_s = ref_state_r;
        period_nxt_s    = period_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        abort_nxt_s     = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                if (bus.meas_start && !bus.seed_load) begin
                    ref_state_nxt_s = state_r;
                    cnt_nxt_s       = ZERO_C;
                    busy_nxt_s      = 1'b1;
                    fsm_nxt_s       = ST_COUNT;
                end else begin
                    busy_nxt_s      = 1'b0;
                end
            end
            ST_COUNT: begin
                if (bus.seed_load || recover_s) begin
                    abort_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b0;
                    fsm_nxt_s   = ST_IDLE;
                end else if (bus.enable) begin
                    // The step that lands back on the reference closes the cycle.
                    if (step_s == ref_state_r) begin
                        period_nxt_s = cnt_r[WIDTH-1:0] + ONE_W;
                        done_nxt_s   = 1'b1;
                        busy_nxt_s   = 1'b0;
                        fsm_nxt_s    = ST_DONE;
                    end else begin
                        cnt_nxt_s    = cnt_r + ONE_C;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
                fsm_nxt_s  = ST_IDLE;
            end
            default: begin
                busy_nxt_s = 1'b0;
                fsm_nxt_s  = ST_IDLE;
            end
        endcase
    end

    // State, measurement and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RESET_SEED;
            ref_state_r <= ZERO_W;
            period_r    <= ZERO_W;
            cnt_r       <= ZERO_C;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            abort_r     <= 1'b0;
            lockup_r    <= 1'b0;
            fsm_r       <= ST_IDLE;
        end else begin
            state_r     <= state_nxt_s;
            ref_state_r <= ref_state_nxt_s;
            period_r    <= period_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            abort_r     <= abort_nxt_s;
            lockup_r    <= recover_s;
            fsm_r       <= fsm_nxt_s;
        end
    end

    assign bus.state      = state_r;
    assign bus.bit_out    = state_r[WIDTH-1];
    assign bus.meas_busy  = busy_r;
    assign bus.meas_done  = done_r;
    assign bus.meas_abort = abort_r;
    assign bus.period     = period_r;
    assign bus.lockup     = lockup_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen in the 4-bit x^4+x+1 configuration.
// Stimulus pushes expected state snapshots and measurement events; a negedge monitor pops and compares.
module tb_lfsr_gen;

    localparam int W = 4;
    localparam int K_ABORT  = 0;
    localparam int K_LOCKUP = 1;
    localparam int K_DONE   = 2;

    typedef struct {
        logic [W-1:0] st;
        logic         busy;
        logic [W-1:0] per;
    } snap_t;

    typedef struct {
        int           kind;
        logic [W-1:0] per;
        int           busy_len;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    lfsr_gen_if #(.WIDTH(W)) bus_if ();

    lfsr_gen #(.WIDTH(W), .TAPS(4'b0010), .RESET_SEED(4'h1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    snap_t q_state[$];
    ev_t   q_ev[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    busy_cnt = 0;
    logic  prev_busy = 1'b0;
    logic  mon_en = 1'b0;

    logic [W-1:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                               4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_state(input logic [W-1:0] st, input logic busy, input logic [W-1:0] per);
        snap_t s;
        s.st = st; s.busy = busy; s.per = per;
        q_state.push_back(s);
    endtask

    task automatic push_ev(input int kind, input logic [W-1:0] per, input int busy_len);
        ev_t e;
        e.kind = kind; e.per = per; e.busy_len = busy_len;
        q_ev.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handle_event(input int kind);
        ev_t e;
        if (q_ev.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = q_ev.pop_front();
            check("event_kind", kind, e.kind);
            check("event_period", {28'd0, bus_if.period}, {28'd0, e.per});
            if (kind == K_DONE) check("busy_cycles", busy_cnt, e.busy_len);
        end
    endtask

    // Monitor: compares queued snapshots and pulses on every falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.meas_busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
            prev_busy = bus_if.meas_busy;
            check("cnt_msb_clear", {31'd0, dut.cnt_r[W]}, 32'd0);
            if (q_state.size() > 0) begin
                snap_t s;
                s = q_state.pop_front();
                check("state", {28'd0, bus_if.state}, {28'd0, s.st});
                check("bit_out", {31'd0, bus_if.bit_out}, {31'd0, s.st[W-1]});
                check("meas_busy", {31'd0, bus_if.meas_busy}, {31'd0, s.busy});
                check("period", {28'd0, bus_if.period}, {28'd0, s.per});
            end
            if (bus_if.meas_abort) handle_event(K_ABORT);
            if (bus_if.lockup)     handle_event(K_LOCKUP);
            if (bus_if.meas_done)  handle_event(K_DONE);
        end
    end

    initial begin
        reset = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.seed_load = 1'b0;
        bus_if.seed = 4'h0;
        bus_if.meas_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Full sequence from reset
        reset = 1'b0;
        bus_if.enable = 1'b1;
        push_state(seq[0], 1'b0, 4'h0);
        for (int k = 1; k < 16; k++) begin
            tick();
            push_state(seq[k], 1'b0, 4'h0);
        end
        bus_if.enable = 1'b0;
        tick();

        // Continuous-enable measurement after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_state(4'h1, 1'b0, 4'h0);
        bus_if.meas_start = 1'b1;
        tick();
        bus_if.meas_start = 1'b0;
        bus_if.enable = 1'b1;
        push_ev(K_DONE, 4'hF, 15);
        repeat (17) tick();
        bus_if.enable = 1'b0;
        repeat (2) tick();

        // Alternating enable measurement
        bus_if.meas_start = 1'b1;
        tick();
        bus_if.meas_start = 1'b0;
        push_ev(K_DONE, 4'hF, 30);
        for (int j = 0; j < 32; j++) begin
            bus_if.enable = (j % 2 == 1);
            tick();
        end
        bus_if.enable = 1'b0;
        repeat (2) tick();

        // Abort by seed load mid-measurement
        bus_if.meas_start = 1'b1;
        tick();
        bus_if.meas_start = 1'b0;
        bus_if.enable = 1'b1;
        repeat (5) tick();
        bus_if.seed_load = 1'b1;
        bus_if.seed = 4'h5;
        push_ev(K_ABORT, 4'hF, 0);
        tick();
        bus_if.seed_load = 1'b0;
        bus_if.enable = 1'b0;
        push_state(4'h5, 1'b0, 4'hF);
        repeat (2) tick();

        // meas_start together with seed_load is ignored
        bus_if.meas_start = 1'b1;
        bus_if.seed_load = 1'b1;
        bus_if.seed = 4'h9;
        tick();
        bus_if.meas_start = 1'b0;
        bus_if.seed_load = 1'b0;
        push_state(4'h9, 1'b0, 4'hF);
        repeat (3) tick();
        push_state(4'h9, 1'b0, 4'hF);

        // Reset mid-measurement: no pulses, back to reset values
        bus_if.meas_start = 1'b1;
        tick();
        bus_if.meas_start = 1'b0;
        bus_if.enable = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_if.enable = 1'b0;
        push_state(4'h1, 1'b0, 4'h0);
        repeat (2) tick();

        // All-zero seed
        bus_if.seed_load = 1'b1;
        bus_if.seed = 4'h0;
        bus_if.enable = 1'b1;
        tick();
        bus_if.seed_load = 1'b0;
        bus_if.enable = 1'b0;
        push_state(4'h0, 1'b0, 4'h0);
        bus_if.meas_start = 1'b1;
        tick();
        bus_if.meas_start = 1'b0;
        bus_if.enable = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
        push_ev(K_ABORT, 4'h0, 0);
        push_ev(K_LOCKUP, 4'h0, 0);
`else
        push_ev(K_DONE, 4'h1, 1);
`endif
        tick();
        bus_if.enable = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        push_state(4'h1, 1'b0, 4'h0);
`else
        push_state(4'h0, 1'b0, 4'h1);
`endif
        repeat (3) tick();

        check("pending_events", q_ev.size(), 32'd0);
        check("pending_states", q_state.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
